ef_smsdac_dsm: RTL and testbench

// - Upstream feeder of the segmented mismatch-shaping encoder.
// - Noise-shapes a wide unsigned sample stream to a 257-level code (0..256) with a 2nd-order error-feedback modulator.
// - Splits the code into x[6:0], x7 and x_c, and supplies the encoder's per-stage random bits r[6:0] from an LFSR.
// - Includes a soft-mute ramp, so enable/disable never steps the DAC.

---
 rtl/ef_smsdac_dsm.sv | 129 ++++++++++++
 tb/tb_ef_smsdac_dsm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_smsdac_dsm.sv
// Second-order error-feedback modulator feeding the segmented mismatch-shaping encoder, with soft-mute ramp and LFSR.
// Optional build macro DITHER_EN adds uniform +/- half-code-step dither ahead of the quantizer.
//
// state   | meaning
// MUTED   | hold parked at midscale, muted asserted
// RAMP_UP | hold stepping toward tgt
// RUN     | hold follows din on din_valid
// RAMP_DN | hold stepping toward midscale
module ef_smsdac_dsm #(
    parameter int          DIN_W     = 16,
    parameter int          RAMP_STEP = 64,
    parameter logic [22:0] LFSR_SEED = 23'h5A5A5A
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    input  logic             din_valid,
    output logic [6:0]       x,
    output logic             x7,
    output logic             x_c,
    output logic [6:0]       r,
    output logic             muted
);

    localparam int S  = DIN_W - 8;
    localparam int VW = DIN_W + 3;
    localparam logic [DIN_W-1:0]     MID  = {1'b1, {(DIN_W-1){1'b0}}};
    localparam logic [DIN_W-1:0]     STEP = DIN_W'(RAMP_STEP);
    localparam logic signed [VW-1:0] HALF = VW'(2 ** (S-1));
    localparam logic signed [VW-1:0] QMAX = VW'(256);

    typedef enum logic [1:0] {MUTED, RAMP_UP, RUN, RAMP_DN} state_t;

    state_t state, state_nxt;
    logic [DIN_W-1:0] hold, hold_nxt, tgt, ramp_dst, ramp_val;
    logic signed [VW-1:0] e1, e2, v, qr, e, dith;
    logic [8:0] q;
    logic sat;
    logic [22:0] lfsr;

`ifdef DITHER_EN
    localparam int DSH_L = (S >= 8) ? S - 8 : 0;
    localparam int DSH_R = (S >= 8) ? 0 : 8 - S;
    logic signed [VW-1:0] d8;
    assign d8   = VW'({1'b0, lfsr[22:15]}) - VW'(128);
    assign dith = (d8 <<< DSH_L) >>> DSH_R;
`else
    assign dith = '0;
`endif

    assign v   = $signed({3'b000, hold}) + (e1 <<< 1) - e2 + dith;
    assign qr  = (v + HALF) >>> S;
    assign sat = qr[VW-1] || (qr > QMAX);
    assign q   = qr[VW-1] ? 9'd0 : (qr > QMAX) ? 9'd256 : qr[8:0];
    assign e   = v - ($signed({{(VW-9){1'b0}}, q}) <<< S);

    // Ramp step toward the destination, clipped so it never overshoots.
    assign ramp_dst = en ? tgt : MID;
    always_comb begin
        if (ramp_dst > hold)
            ramp_val = (ramp_dst - hold > STEP) ? hold + STEP : ramp_dst;
        else
            ramp_val = (hold - ramp_dst > STEP) ? hold - STEP : ramp_dst;
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        case (state)
            MUTED: begin
                hold_nxt = MID;
                if (en) state_nxt = RAMP_UP;
            end
            RAMP_UP, RAMP_DN: begin
                hold_nxt = ramp_val;
                if (en)
                    state_nxt = (ramp_val == tgt) ? RUN : RAMP_UP;
                else
                    state_nxt = (ramp_val == MID) ? MUTED : RAMP_DN;
            end
            RUN: begin
                if (!en)
                    state_nxt = RAMP_DN;
                else if (din_valid)
                    hold_nxt = din;
            end
            default: begin
                state_nxt = MUTED;
                hold_nxt  = MID;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= MUTED;
            hold  <= MID;
            tgt   <= MID;
            e1    <= '0;
            e2    <= '0;
            lfsr  <= LFSR_SEED;
            x     <= 7'd0;
            x7    <= 1'b1;
            x_c   <= 1'b0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            if (din_valid) tgt <= din;
            // Clearing the error history on overload prevents limit-cycle lockup.
            e2    <= sat ? '0 : e1;
            e1    <= sat ? '0 : e;
            lfsr  <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
            if (q[8]) begin
                x7  <= 1'b1;
                x   <= 7'h7F;
                x_c <= 1'b1;
            end else begin
                x7  <= q[7];
                x   <= q[6:0];
                x_c <= 1'b0;
            end
        end
    end

    assign r     = lfsr[6:0];
    assign muted = (state == MUTED);

endmodule

// File: tb/tb_ef_smsdac_dsm.sv
// Randomized self-checking bench for ef_smsdac_dsm against an integer reference model.
module tb_ef_smsdac_dsm;

    localparam int          DIN_W = 16;
    localparam int          STEP  = 64;
    localparam logic [22:0] SEED  = 23'h5A5A5A;
    localparam int          MID   = 32768;
    localparam int M_MUTED = 0, M_UP = 1, M_RUN = 2, M_DN = 3;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             en = 1'b0;
    logic [DIN_W-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic [6:0]       x;
    logic             x7;
    logic             x_c;
    logic [6:0]       r;
    logic             muted;

    int errors = 0;
    int checks = 0;

    int          m_mode, m_hold, m_tgt, m_e1, m_e2, m_code;
    logic [22:0] m_lfsr;

    ef_smsdac_dsm #(.DIN_W(DIN_W), .RAMP_STEP(STEP), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst_b(rst_b), .en(en), .din(din), .din_valid(din_valid),
        .x(x), .x7(x7), .x_c(x_c), .r(r), .muted(muted)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(int a, int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int clamp_step(int diff);
        if (diff > STEP) return STEP;
        if (diff < -STEP) return -STEP;
        return diff;
    endfunction

    function automatic logic [8:0] exp_split(int c);
        logic [8:0] o;
        if (c == 256) o = {1'b1, 7'd127, 1'b1};
        else          o = {c / 128 == 1, 7'(c % 128), 1'b0};
        return o;
    endfunction

    task automatic model_reset();
        m_mode = M_MUTED; m_hold = MID; m_tgt = MID;
        m_e1 = 0; m_e2 = 0; m_code = 128; m_lfsr = SEED;
    endtask

    task automatic model_step(input bit en_i, input int din_i, input bit dv_i);
        int d, vv, qq, ee, dst;
        bit sat;
        d = 0;
`ifdef DITHER_EN
        d = int'(m_lfsr[22:15]) - 128;
`endif
        vv  = m_hold + 2 * m_e1 - m_e2 + d;
        qq  = floor_div(vv + 128, 256);
        sat = (qq < 0) || (qq > 256);
        if (qq < 0) qq = 0;
        if (qq > 256) qq = 256;
        ee = vv - qq * 256;
        m_e2 = sat ? 0 : m_e1;
        m_e1 = sat ? 0 : ee;
        m_code = qq;
        m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
        case (m_mode)
            M_MUTED: begin
                m_hold = MID;
                if (en_i) m_mode = M_UP;
            end
            M_UP, M_DN: begin
                dst = en_i ? m_tgt : MID;
                m_hold = m_hold + clamp_step(dst - m_hold);
                if (en_i) m_mode = (m_hold == m_tgt) ? M_RUN : M_UP;
                else      m_mode = (m_hold == MID) ? M_MUTED : M_DN;
            end
            default: begin
                if (!en_i) m_mode = M_DN;
                else if (dv_i) m_hold = din_i;
            end
        endcase
        if (dv_i) m_tgt = din_i;
    endtask

    task automatic tick(input bit en_i, input logic [DIN_W-1:0] din_i, input bit dv_i);
        en = en_i; din = din_i; din_valid = dv_i;
        @(posedge clk);
        if (!rst_b) model_reset();
        else model_step(en_i, int'(din_i), dv_i);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        tick(1'b1, 16'h1234, 1'b1);
        tick(1'b1, 16'h1234, 1'b1);
        checks++; if (x !== 7'd0) begin errors++; $display("FAIL reset_x got=%0d exp=0", x); end
        checks++; if (x7 !== 1'b1) begin errors++; $display("FAIL reset_x7 got=%0b exp=1", x7); end
        checks++; if (x_c !== 1'b0) begin errors++; $display("FAIL reset_xc got=%0b exp=0", x_c); end
        checks++; if (muted !== 1'b1) begin errors++; $display("FAIL reset_muted got=%0b exp=1", muted); end
        checks++; if (r !== SEED[6:0]) begin errors++; $display("FAIL reset_r got=%h exp=%h", r, SEED[6:0]); end
        rst_b = 1'b1;
    endtask

    task automatic test_dc_ramp();
        longint sum = 0;
        real mean;
        tick(1'b1, 16'hC000, 1'b1);
        for (int i = 0; i < 259; i++) begin
            tick(1'b1, 16'h0000, 1'b0);
            checks++;
            if ({x7, x, x_c} !== exp_split(m_code)) begin
                errors++; $display("FAIL dc_ramp_code cyc=%0d got=%h exp=%h", i, {x7, x, x_c}, exp_split(m_code));
            end
        end
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL dc_ramp_muted got=%0b exp=0", muted); end
        checks++; if (dut.hold !== 16'hC000) begin errors++; $display("FAIL dc_ramp_hold got=%h exp=c000", dut.hold); end
        for (int i = 0; i < 4096; i++) begin
            tick(1'b1, 16'h0000, 1'b0);
            sum += 128 * x7 + x + x_c;
        end
        mean = real'(sum) / 4096.0;
        checks++;
        if (mean < 191.95 || mean > 192.05) begin errors++; $display("FAIL dc_mean got=%f exp=192.0", mean); end
    endtask

    task automatic test_full_scale();
        int c;
        tick(1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b1, 16'hFFFF, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 16'hFFFF, 1'b0);
            c = 128 * x7 + x + x_c;
            checks++;
            if (c != 255 && c != 256) begin errors++; $display("FAIL full_scale_code got=%0d exp=255/256", c); end
            checks++;
            if (x_c && !(x == 7'd127 && x7)) begin
                errors++; $display("FAIL full_scale_split got x=%0d x7=%0b exp x=127 x7=1", x, x7);
            end
            checks++;
            if ({x7, x, x_c} !== exp_split(m_code)) begin
                errors++; $display("FAIL full_scale_model got=%h exp=%h", {x7, x, x_c}, exp_split(m_code));
            end
        end
    endtask

    task automatic test_bottom();
        tick(1'b1, 16'h0000, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 16'h0000, 1'b0);
            checks++;
            if ({x7, x, x_c} !== 9'd0) begin errors++; $display("FAIL bottom_code got=%h exp=0", {x7, x, x_c}); end
            checks++;
            if (dut.e1 !== '0 || dut.e2 !== '0) begin
                errors++; $display("FAIL bottom_err got e1=%0d e2=%0d exp 0/0", dut.e1, dut.e2);
            end
        end
    endtask

    task automatic test_mute_mid_ramp();
        int prev, cur;
        rst_b = 1'b0;
        tick(1'b0, 16'h8000, 1'b0);
        rst_b = 1'b1;
        tick(1'b1, 16'hF000, 1'b1);
        prev = int'(dut.hold);
        for (int i = 0; i < 30; i++) begin
            tick(i < 10, 16'hF000, 1'b0);
            cur = int'(dut.hold);
            checks++;
            if (cur - prev > STEP || prev - cur > STEP) begin
                errors++; $display("FAIL mute_step got=%0d exp<=%0d", cur - prev, STEP);
            end
            checks++;
            if (cur != m_hold) begin errors++; $display("FAIL mute_hold cyc=%0d got=%h exp=%h", i, cur, m_hold); end
            prev = cur;
        end
        checks++; if (muted !== 1'b1) begin errors++; $display("FAIL mute_end_muted got=%0b exp=1", muted); end
        checks++; if (dut.hold !== 16'h8000) begin errors++; $display("FAIL mute_end_hold got=%h exp=8000", dut.hold); end
    endtask

    task automatic test_random();
        bit e_i = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) e_i = ~e_i;
            rst_b = ($urandom_range(0, 499) != 0);
            tick(e_i, DIN_W'($urandom), $urandom_range(0, 3) == 0);
            checks++;
            if ({x7, x, x_c, r, muted} !== {exp_split(m_code), m_lfsr[6:0], m_mode == M_MUTED}) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, {x7, x, x_c, r, muted},
                         {exp_split(m_code), m_lfsr[6:0], m_mode == M_MUTED});
            end
            if (!rst_b) begin
                rst_b = 1'b1;
                tick(e_i, 16'h8000, 1'b0);
                checks++;
                if ({x7, x, x_c} !== 9'h100) begin errors++; $display("FAIL post_reset_code got=%h exp=100", {x7, x, x_c}); end
            end
        end
        rst_b = 1'b1;
    endtask

    task automatic test_lfsr();
        for (int i = 0; i < 65536; i++) begin
            tick(1'b0, 16'h8000, 1'b0);
            checks++;
            if (r !== m_lfsr[6:0]) begin errors++; $display("FAIL lfsr cyc=%0d got=%h exp=%h", i, r, m_lfsr[6:0]); end
        end
    endtask

`ifdef DITHER_EN
    task automatic test_dither_mean();
        longint sum = 0;
        real mean;
        tick(1'b1, 16'h8080, 1'b1);
        for (int i = 0; i < 300; i++) tick(1'b1, 16'h8080, 1'b0);
        for (int i = 0; i < 4096; i++) begin
            tick(1'b1, 16'h8080, 1'b0);
            sum += 128 * x7 + x + x_c;
        end
        mean = real'(sum) / 4096.0;
        checks++;
        if (mean < 128.45 || mean > 128.55) begin errors++; $display("FAIL dither_mean got=%f exp=128.5", mean); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_dc_ramp();
        test_full_scale();
        test_bottom();
        test_mute_mid_ramp();
        test_random();
        test_lfsr();
`ifdef DITHER_EN
        test_dither_mean();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
